// File: rtl/mem_stage_if.sv
// Bundle of the MEM stage's pipeline buses: EX-side inputs, SRAM read data, and the
// MEM->WB bus plus forwarding outputs. The EX side/driver uses master, the stage uses slave.
interface mem_stage_if #(
  parameter int EX_TO_MEM_WD = 76,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_WD     = 6
);
  logic [STALL_WD-1:0]     stall;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [65:0]             hilo_ex_to_mem_bus;
  logic [2:0]              ex_ld_op;
  logic [31:0]             data_sram_rdata;
  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
  logic [65:0]             hilo_mem_to_wb_bus;
  logic                    mem_wreg;
  logic [4:0]              mem_waddr;
  logic [31:0]             mem_wdata;
  logic                    mem_hi_we;
  logic                    mem_lo_we;
  logic [31:0]             mem_hi_wdata;
  logic [31:0]             mem_lo_wdata;
  logic                    mem_adel;

  // Handshake: there is no valid/ready pair; flow is governed by stall (1 = Stop),
  // stall[3] holds the MEM stage and stall[4] the WB stage behind it.
  modport master (
    output stall, ex_to_mem_bus, hilo_ex_to_mem_bus, ex_ld_op, data_sram_rdata,
    input  mem_to_wb_bus, hilo_mem_to_wb_bus, mem_wreg, mem_waddr, mem_wdata,
    input  mem_hi_we, mem_lo_we, mem_hi_wdata, mem_lo_wdata, mem_adel
  );

  modport slave (
    input  stall, ex_to_mem_bus, hilo_ex_to_mem_bus, ex_ld_op, data_sram_rdata,
    output mem_to_wb_bus, hilo_mem_to_wb_bus, mem_wreg, mem_waddr, mem_wdata,
    output mem_hi_we, mem_lo_we, mem_hi_wdata, mem_lo_wdata, mem_adel
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: registers EX->MEM and HI/LO buses, aligns/extends SRAM load data.
// Optional misaligned-load flag enabled by defining MEM_ADDR_EXC_EN.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 76,
  parameter int MEM_TO_WB_WD = 70,
  parameter int STALL_WD     = 6
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave mem_if
);
  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_q, ex_to_mem_d;
  logic [65:0]             hilo_q, hilo_d;
  logic [2:0]              ld_op_q, ld_op_d;

  logic stop_mem, stop_wb;
  assign stop_mem = mem_if.stall[3];
  assign stop_wb  = mem_if.stall[4];

  // A stalled MEM with a free WB must not let WB re-consume this instruction: insert a bubble.
  always_comb begin
    ex_to_mem_d = ex_to_mem_q;
    hilo_d      = hilo_q;
    ld_op_d     = ld_op_q;
    if (stop_mem && !stop_wb) begin
      ex_to_mem_d = '0;
      hilo_d      = '0;
      ld_op_d     = '0;
    end else if (!stop_mem) begin
      ex_to_mem_d = mem_if.ex_to_mem_bus;
      hilo_d      = mem_if.hilo_ex_to_mem_bus;
      ld_op_d     = mem_if.ex_ld_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_to_mem_q <= '0;
      hilo_q      <= '0;
      ld_op_q     <= '0;
    end else begin
      ex_to_mem_q <= ex_to_mem_d;
      hilo_q      <= hilo_d;
      ld_op_q     <= ld_op_d;
    end
  end

  logic [31:0] pc;
  logic        sel_rf_res, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [1:0]  addr_lo;

  assign pc         = ex_to_mem_q[75:44];
  assign sel_rf_res = ex_to_mem_q[38];
  assign rf_we      = ex_to_mem_q[37];
  assign rf_waddr   = ex_to_mem_q[36:32];
  assign ex_result  = ex_to_mem_q[31:0];
  assign addr_lo    = ex_result[1:0];

  logic [31:0] rdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign rdata = mem_if.data_sram_rdata;

  always_comb begin
    ld_byte = rdata[7:0];
    case (addr_lo)
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_op_q)
      LD_LW:   load_data = rdata;
      LD_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LBU:  load_data = {24'd0, ld_byte};
      LD_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      LD_LHU:  load_data = {16'd0, ld_half};
      default: load_data = '0;
    endcase
  end

  logic adel;
`ifdef MEM_ADDR_EXC_EN
  always_comb begin
    adel = 1'b0;
    if (sel_rf_res) begin
      case (ld_op_q)
        LD_LW:         adel = (addr_lo != 2'd0);
        LD_LH, LD_LHU: adel = addr_lo[0];
        default:       adel = 1'b0;
      endcase
    end
  end
`else
  assign adel = 1'b0;
`endif

  logic        rf_we_out;
  logic [31:0] rf_wdata;
  assign rf_we_out = rf_we & ~adel;
  assign rf_wdata  = sel_rf_res ? load_data : ex_result;

  assign mem_if.mem_to_wb_bus      = MEM_TO_WB_WD'({pc, rf_we_out, rf_waddr, rf_wdata});
  assign mem_if.hilo_mem_to_wb_bus = hilo_q;
  assign mem_if.mem_wreg           = rf_we_out;
  assign mem_if.mem_waddr          = rf_waddr;
  assign mem_if.mem_wdata          = rf_wdata;
  assign mem_if.mem_hi_wdata       = hilo_q[65:34];
  assign mem_if.mem_lo_wdata       = hilo_q[33:2];
  assign mem_if.mem_hi_we          = hilo_q[1];
  assign mem_if.mem_lo_we          = hilo_q[0];
  assign mem_if.mem_adel           = adel;

  // ram_en/ram_wen were consumed by the SRAM request in EX; other stall bits belong to other stages.
  logic unused_bits;
  assign unused_bits = ^{ex_to_mem_q[43:39], mem_if.stall[2:0], mem_if.stall[STALL_WD-1]};
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: spec vectors, stall/reset sequences and a random run
// against a behavioural model. Honours MEM_ADDR_EXC_EN the same way as the design.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if mif ();
  mem_stage dut (.clk(clk), .rst(rst), .mem_if(mif));

  typedef struct packed {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] ex_result;
    logic [65:0] hilo;
    logic [2:0]  ld_op;
  } txn_t;

  typedef struct packed {
    logic [69:0] wb_bus;
    logic [65:0] hilo_bus;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        adel;
  } exp_t;

  typedef struct packed {
    txn_t        t;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        exp_adel;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  txn_t        mdl_q;
  txn_t        cur_t;
  logic [5:0]  cur_stall;
  logic [31:0] cur_rdata;
  logic        cur_rst;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic misaligned(input txn_t t);
    int a;
    a = int'(t.ex_result[1:0]);
`ifdef MEM_ADDR_EXC_EN
    if (!t.sel) return 1'b0;
    if (t.ld_op == 3'd0) return a != 0;
    if (t.ld_op == 3'd3 || t.ld_op == 3'd4) return (a % 2) == 1;
    return 1'b0;
`else
    return (a < 0);
`endif
  endfunction

  function automatic exp_t model_out(input txn_t t, input logic [31:0] rdata);
    exp_t        e;
    int          a;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    a = int'(t.ex_result[1:0]);
    b = 8'(rdata >> (8 * a));
    h = 16'(rdata >> ((a >= 2) ? 16 : 0));
    case (t.ld_op)
      3'd0:    ld = rdata;
      3'd1:    ld = 32'($signed(b));
      3'd2:    ld = 32'(b);
      3'd3:    ld = 32'($signed(h));
      3'd4:    ld = 32'(h);
      default: ld = 32'd0;
    endcase
    e.adel     = misaligned(t);
    e.wdata    = t.sel ? ld : t.ex_result;
    e.wreg     = t.rf_we && !e.adel;
    e.waddr    = t.waddr;
    e.wb_bus   = {t.pc, e.wreg, t.waddr, e.wdata};
    e.hilo_bus = t.hilo;
    return e;
  endfunction

  task automatic drive(input txn_t t, input logic [5:0] stall, input logic [31:0] rdata, input logic r);
    cur_t = t; cur_stall = stall; cur_rdata = rdata; cur_rst = r;
    rst = r;
    mif.stall              = stall;
    mif.ex_to_mem_bus      = {t.pc, t.ram_en, t.ram_wen, t.sel, t.rf_we, t.waddr, t.ex_result};
    mif.hilo_ex_to_mem_bus = t.hilo;
    mif.ex_ld_op           = t.ld_op;
    mif.data_sram_rdata    = rdata;
  endtask

  // One clock: the model applies the stage's update rule to what was presented at the edge.
  task automatic step();
    @(posedge clk);
    if (cur_rst || (cur_stall[3] && !cur_stall[4])) mdl_q = '0;
    else if (!cur_stall[3]) mdl_q = cur_t;
    #1;
  endtask

  task automatic check_all(input string tag);
    exp_t e;
    e = model_out(mdl_q, cur_rdata);
    check({tag, ".wb_bus"},   mif.mem_to_wb_bus, e.wb_bus);
    check({tag, ".hilo_bus"}, 70'(mif.hilo_mem_to_wb_bus), 70'(e.hilo_bus));
    check({tag, ".wreg"},     70'(mif.mem_wreg), 70'(e.wreg));
    check({tag, ".waddr"},    70'(mif.mem_waddr), 70'(e.waddr));
    check({tag, ".wdata"},    70'(mif.mem_wdata), 70'(e.wdata));
    check({tag, ".hi"},       70'({mif.mem_hi_we, mif.mem_hi_wdata}), 70'({e.hilo_bus[1], e.hilo_bus[65:34]}));
    check({tag, ".lo"},       70'({mif.mem_lo_we, mif.mem_lo_wdata}), 70'({e.hilo_bus[0], e.hilo_bus[33:2]}));
    check({tag, ".adel"},     70'(mif.mem_adel), 70'(e.adel));
  endtask

  function automatic txn_t mk(input logic sel, input logic we, input logic [4:0] wa,
                              input logic [31:0] res, input logic [2:0] op);
    txn_t t;
    t.pc = 32'hBFC0_0100; t.ram_en = sel; t.ram_wen = 4'h0; t.sel = sel; t.rf_we = we;
    t.waddr = wa; t.ex_result = res; t.hilo = {32'h1111_2222, 32'h3333_4444, 2'b10}; t.ld_op = op;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.pc = $urandom; t.ram_en = 1'($urandom); t.ram_wen = 4'($urandom);
    t.sel = 1'($urandom); t.rf_we = 1'($urandom); t.waddr = 5'($urandom);
    t.ex_result = $urandom; t.hilo = {$urandom, $urandom, 2'($urandom)};
    t.ld_op = 3'($urandom_range(0, 5));
    return t;
  endfunction

  vec_t vecs[9];
  txn_t t;
  logic [31:0] rd;
  logic [5:0]  st;
  logic        r;

  initial begin
    logic adel_on;
`ifdef MEM_ADDR_EXC_EN
    adel_on = 1'b1;
`else
    adel_on = 1'b0;
`endif
    vecs[0] = '{mk(1, 1, 5'd5, 32'h0000_1003, 3'd1), 32'h80FF_1234, 32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[1] = '{mk(1, 1, 5'd6, 32'h0000_2002, 3'd4), 32'hBEEF_0001, 32'h0000_BEEF, 1'b1, 1'b0};
    vecs[2] = '{mk(1, 1, 5'd7, 32'h0000_2002, 3'd3), 32'hBEEF_0001, 32'hFFFF_BEEF, 1'b1, 1'b0};
    vecs[3] = '{mk(0, 1, 5'd8, 32'h1234_5678, 3'd0), 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0};
    vecs[4] = '{mk(1, 1, 5'd9, 32'h0000_0001, 3'd2), 32'h0000_A500, 32'h0000_00A5, 1'b1, 1'b0};
    vecs[5] = '{mk(1, 1, 5'd10, 32'h0000_0010, 3'd1), 32'h1234_567F, 32'h0000_007F, 1'b1, 1'b0};
    vecs[6] = '{mk(1, 1, 5'd11, 32'h0000_0000, 3'd5), 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{mk(0, 0, 5'd12, 32'h0000_0040, 3'd0), 32'h5555_AAAA, 32'h0000_0040, 1'b0, 1'b0};
    vecs[7].t.ram_wen = 4'hF;
    vecs[8] = '{mk(1, 1, 5'd13, 32'h0000_0102, 3'd0), 32'hCAFE_F00D, 32'hCAFE_F00D, !adel_on, adel_on};

    mdl_q = '0;
    // Reset with busy inputs: every output must read 0.
    drive(rand_txn(), 6'b000000, $urandom, 1'b1);
    step();
    check("reset.wb_bus", mif.mem_to_wb_bus, 70'd0);
    check("reset.hilo_bus", 70'(mif.hilo_mem_to_wb_bus), 70'd0);
    check("reset.wdata", 70'(mif.mem_wdata), 70'd0);
    check_all("reset");

    foreach (vecs[i]) begin
      drive(vecs[i].t, 6'b000000, vecs[i].rdata, 1'b0);
      step();
      check($sformatf("vec%0d.wdata", i), 70'(mif.mem_wdata), 70'(vecs[i].exp_wdata));
      check($sformatf("vec%0d.wreg", i), 70'(mif.mem_wreg), 70'(vecs[i].exp_we));
      check($sformatf("vec%0d.waddr", i), 70'(mif.mem_waddr), 70'(vecs[i].t.waddr));
      check($sformatf("vec%0d.adel", i), 70'(mif.mem_adel), 70'(vecs[i].exp_adel));
      check($sformatf("vec%0d.hilo", i), 70'(mif.hilo_mem_to_wb_bus), 70'(vecs[i].t.hilo));
      check_all($sformatf("vec%0d", i));
    end

    // Bubble: MEM stopped, WB free -> stage empties.
    drive(vecs[0].t, 6'b000000, vecs[0].rdata, 1'b0);
    step();
    drive(vecs[3].t, 6'b001111, vecs[0].rdata, 1'b0);
    step();
    check("bubble.wb_bus", mif.mem_to_wb_bus, 70'd0);
    check("bubble.hilo_bus", 70'(mif.hilo_mem_to_wb_bus), 70'd0);
    check_all("bubble");

    // Held stall: the lh load stays in MEM for three cycles while EX offers something else.
    drive(vecs[2].t, 6'b000000, vecs[2].rdata, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(vecs[3].t, 6'b011111, vecs[2].rdata, 1'b0);
      step();
      check($sformatf("hold%0d.wdata", k), 70'(mif.mem_wdata), 70'h0_FFFF_BEEF);
      check($sformatf("hold%0d.waddr", k), 70'(mif.mem_waddr), 70'd7);
      check_all($sformatf("hold%0d", k));
    end

    // Reset during the held load wins.
    drive(vecs[3].t, 6'b011111, vecs[2].rdata, 1'b1);
    step();
    check("rst_hold.wb_bus", mif.mem_to_wb_bus, 70'd0);
    check("rst_hold.wreg", 70'(mif.mem_wreg), 70'd0);
    check_all("rst_hold");

    // Random run; SRAM data stays put whenever MEM is held.
    rd = $urandom;
    for (int n = 0; n < 400; n++) begin
      st = 6'($urandom);
      st[3] = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 49) == 0);
      if (!(cur_stall[3] && cur_stall[4] && !cur_rst)) rd = $urandom;
      t = rand_txn();
      if ($urandom_range(0, 1) == 1) t.ex_result[1:0] = 2'($urandom);
      drive(t, st, rd, r);
      step();
      check_all($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
